// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - key code valid/ack handshake between scanner and consumer
interface keypad_scan_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_pressed;
  logic       key_overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_pressed,
    output key_overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_pressed,
    input  key_overrun,
    output key_ack
  );
endinterface

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with scan-based debounce and valid/ack output
module keypad_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          sys_clk_100M,
  input  logic          sys_rst,
  input  logic [3:0]    btn_key_row,
  output logic [3:0]    btn_key_col,
  keypad_scan_if.master key_if
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_CAND, S_PRESSED, S_RELEASE} state_t;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic             acc_hit;
  logic [3:0]       acc_code;

  state_t     state;
  logic [3:0] cand;
  logic [3:0] cnt;
  logic [3:0] code_q;
  logic       valid_q;
  logic       pressed_q;
  logic       overrun_q;

  logic       sample;
  logic       scan_end;
  logic       row_hit;
  logic [1:0] row_idx;
  logic       res_hit;
  logic [3:0] res_code;
  logic [3:0] cnt_inc;
  logic       accept;
  logic [3:0] accept_code;

  // Lowest low row wins within a column; the accumulator keeps the earliest column's hit.
  always_comb begin
    sample   = (div_cnt == DIV_LAST);
    scan_end = sample && (col_idx == 2'd3);
    row_hit  = ~&row_sync;
    row_idx  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync[i]) row_idx = 2'(i);
    end
    res_hit     = acc_hit | row_hit;
    res_code    = acc_hit ? acc_code : {row_idx, col_idx};
    cnt_inc     = cnt + 4'd1;
    accept      = scan_end && res_hit &&
                  (((state == S_IDLE) && (DEB_N == 4'd1)) ||
                   ((state == S_CAND) && (res_code == cand) && (cnt_inc == DEB_N)));
    accept_code = (state == S_IDLE) ? res_code : cand;
  end

  assign btn_key_col = ~(4'b0001 << col_idx);

  always_ff @(posedge sys_clk_100M) begin
    if (sys_rst) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
      div_cnt  <= '0;
      col_idx  <= 2'd0;
      acc_hit  <= 1'b0;
      acc_code <= 4'd0;
    end else begin
      row_meta <= btn_key_row;
      row_sync <= row_meta;
      if (sample) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        if (scan_end) begin
          acc_hit  <= 1'b0;
          acc_code <= 4'd0;
        end else if (!acc_hit && row_hit) begin
          acc_hit  <= 1'b1;
          acc_code <= {row_idx, col_idx};
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk_100M) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      cand      <= 4'd0;
      cnt       <= 4'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // A new accept overrides a simultaneous ack; only an unacked pending code is an overrun.
      if (accept) begin
        code_q  <= accept_code;
        valid_q <= 1'b1;
        if (valid_q && !key_if.key_ack) overrun_q <= 1'b1;
        else if (valid_q)               overrun_q <= 1'b0;
      end else if (valid_q && key_if.key_ack) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      if (scan_end) begin
        case (state)
          S_IDLE: begin
            if (res_hit) begin
              if (DEB_N == 4'd1) begin
                state     <= S_PRESSED;
                pressed_q <= 1'b1;
              end else begin
                state <= S_CAND;
                cand  <= res_code;
                cnt   <= 4'd1;
              end
            end
          end
          S_CAND: begin
            if (!res_hit) begin
              state <= S_IDLE;
            end else if (res_code == cand) begin
              if (cnt_inc == DEB_N) begin
                state     <= S_PRESSED;
                pressed_q <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cand <= res_code;
              cnt  <= 4'd1;
            end
          end
          S_PRESSED: begin
            if (!res_hit) begin
              if (DEB_N == 4'd1) begin
                state     <= S_IDLE;
                pressed_q <= 1'b0;
              end else begin
                state <= S_RELEASE;
                cnt   <= 4'd1;
              end
            end
          end
          S_RELEASE: begin
            if (res_hit) begin
              state <= S_PRESSED;
            end else if (cnt_inc == DEB_N) begin
              state     <= S_IDLE;
              pressed_q <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign key_if.key_code    = code_q;
  assign key_if.key_valid   = valid_q;
  assign key_if.key_pressed = pressed_q;
  assign key_if.key_overrun = overrun_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed self-checking bench for keypad_scan
module tb_keypad_scan;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn_key_row;
  logic [3:0]  btn_key_col;
  logic [15:0] keys = 16'h0000;
  int          phase;
  int          n_cmp = 0;
  int          n_err = 0;

  keypad_scan_if key_if ();

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .sys_clk_100M (clk),
    .sys_rst      (rst),
    .btn_key_row  (btn_key_row),
    .btn_key_col  (btn_key_col),
    .key_if       (key_if)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    btn_key_row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !btn_key_col[c]) btn_key_row[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) phase <= 0;
    else     phase <= phase + 1;
  end

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  exp_code;
    string       name;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int took);
    took = 0;
    while (!key_if.key_valid && took < budget) begin
      @(negedge clk);
      took++;
    end
  endtask

  task automatic wait_unpressed(input int budget, output int took);
    took = 0;
    while (key_if.key_pressed && took < budget) begin
      @(negedge clk);
      took++;
    end
  endtask

  task automatic align_scan();
    int guard = 0;
    while ((phase % 16) != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic do_ack();
    key_if.key_ack = 1'b1;
    @(negedge clk);
    key_if.key_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"},     btn_key_col,        4'b1110);
    check({tag, "_code"},    key_if.key_code,    0);
    check({tag, "_valid"},   key_if.key_valid,   0);
    check({tag, "_pressed"}, key_if.key_pressed, 0);
    check({tag, "_overrun"}, key_if.key_overrun, 0);
  endtask

  vec_t        vecs[6];
  logic [3:0]  exp_cols[5];
  int          took;
  bit          seen;

  initial begin
    vecs[0] = '{16'h0001, 4'd0,  "k0"};
    vecs[1] = '{16'h0420, 4'd5,  "k5_k10"};
    vecs[2] = '{16'h0012, 4'd4,  "k1_k4"};
    vecs[3] = '{16'h00C0, 4'd6,  "k6_k7"};
    vecs[4] = '{16'h0200, 4'd9,  "k9"};
    vecs[5] = '{16'h1000, 4'd12, "k12"};
    exp_cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    key_if.key_ack = 1'b0;

    @(negedge clk);
    step(5);
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int k = 0; k < 20; k++) begin
      check($sformatf("scan_col_%0d", k), btn_key_col, exp_cols[k/4]);
      step(1);
    end

    foreach (vecs[i]) begin
      keys = vecs[i].keys;
      wait_valid(60, took);
      check({vecs[i].name, "_valid"},   key_if.key_valid, 1);
      check({vecs[i].name, "_lat_ok"},  (took <= 51), 1);
      check({vecs[i].name, "_code"},    key_if.key_code, vecs[i].exp_code);
      check({vecs[i].name, "_pressed"}, key_if.key_pressed, 1);
      step(3);
      check({vecs[i].name, "_hold"},    key_if.key_valid, 1);
      do_ack();
      check({vecs[i].name, "_ackfall"}, key_if.key_valid, 0);
      keys = 16'h0000;
      wait_unpressed(60, took);
      check({vecs[i].name, "_release"}, key_if.key_pressed, 0);
    end

    keys = 16'h8000;
    wait_valid(60, took);
    check("hold_code", key_if.key_code, 15);
    check("hold_pressed", key_if.key_pressed, 1);
    do_ack();
    seen = 1'b0;
    repeat (64) begin
      step(1);
      if (key_if.key_valid) seen = 1'b1;
    end
    check("hold_no_repeat", seen, 0);
    check("hold_still_pressed", key_if.key_pressed, 1);
    keys = 16'h0000;
    wait_unpressed(60, took);
    check("hold_release", key_if.key_pressed, 0);
    check("hold_release_min", (took >= 17), 1);

    align_scan();
    keys = 16'h0008;
    step(16);
    keys = 16'h0000;
    seen = 1'b0;
    repeat (80) begin
      step(1);
      if (key_if.key_valid || key_if.key_pressed) seen = 1'b1;
    end
    check("bounce_quiet", seen, 0);

    keys = 16'h0040;
    wait_valid(60, took);
    check("ovr1_code6", key_if.key_code, 6);
    keys = 16'h0000;
    wait_unpressed(60, took);
    keys = 16'h0200;
    took = 0;
    while (key_if.key_code != 4'd9 && took < 60) begin
      step(1);
      took++;
    end
    check("ovr1_code9", key_if.key_code, 9);
    check("ovr1_valid", key_if.key_valid, 1);
    check("ovr1_overrun", key_if.key_overrun, 1);
    do_ack();
    check("ovr1_ack_valid", key_if.key_valid, 0);
    check("ovr1_ack_overrun", key_if.key_overrun, 0);
    keys = 16'h0000;
    wait_unpressed(60, took);

    keys = 16'h0040;
    wait_valid(60, took);
    keys = 16'h0000;
    wait_unpressed(60, took);
    align_scan();
    keys = 16'h0200;
    step(31);
    check("ovr2_pending_code", key_if.key_code, 6);
    check("ovr2_pending_valid", key_if.key_valid, 1);
    key_if.key_ack = 1'b1;
    step(1);
    key_if.key_ack = 1'b0;
    check("ovr2_valid", key_if.key_valid, 1);
    check("ovr2_code", key_if.key_code, 9);
    check("ovr2_overrun", key_if.key_overrun, 0);
    do_ack();
    check("ovr2_ack_valid", key_if.key_valid, 0);
    keys = 16'h0000;
    wait_unpressed(60, took);

    align_scan();
    keys = 16'h0001;
    step(16);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    check_reset_outputs("midrst");
    wait_valid(60, took);
    check("midrst_fresh_debounce", (took >= 30 && took <= 51), 1);
    check("midrst_code", key_if.key_code, 0);
    do_ack();
    keys = 16'h0000;
    wait_unpressed(60, took);
    check("midrst_release", key_if.key_pressed, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Synthesizable 4x4 matrix-keypad scanner for the MiniMIPS32 SoC. It drives `btn_key_col` one column at a time and samples `btn_key_row`, which is the side of the keypad interface that the system bench stimulates. Each key press is debounced, encoded as a 4-bit key code and presented to the CPU-side peripheral logic through a valid/ack handshake.

## Interface
- `SCAN_DIV`, default 100000: clock cycles each column is driven. The default gives 1 ms at 100 MHz. Must be at least 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-scan results required to accept a press or a release. Range 1..15.
- `sys_clk_100M`  in  1  system clock; all logic runs on its rising edge.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `btn_key_row`  in  4  keypad rows, active-low (pulled up; a pressed key pulls its row low while its column is driven).
- `btn_key_col`  out  4  keypad column drive, active-low one-hot.
- `key_code`  out  4  last accepted key, computed as row_idx*4 + col_idx.
- `key_valid`  out  1  a new key code is pending for the consumer.
- `key_ack`  in  1  consumer accepts `key_code`; only meaningful while `key_valid`=1.
- `key_pressed`  out  1  level; 1 while the accepted key is held (debounced).
- `key_overrun`  out  1  sticky; a key event was lost because the previous one was not yet acknowledged.

## Operation
- **Row synchronizer.** `btn_key_row` passes through a 2-flop synchronizer. Its reset value is 4'b1111.
- **Column scanning.**
  - A divider counts 0..SCAN_DIV-1.
  - `col_idx` (0..3) advances when the divider wraps, and wraps 3→0.
  - `btn_key_col` = ~(4'b0001 << col_idx). Column 0 is 4'b1110 and column 3 is 4'b0111.
- **Row sampling.**
  - Synchronized rows are sampled when the divider reaches SCAN_DIV-1, the last cycle of each column.
  - The first low row bit, taking the lowest col_idx first and then the lowest row_idx, is kept as the scan candidate. Later hits in the same scan are ignored.
  - A scan ends at the col 3 sample. Its result is either NONE or the candidate code; the scan accumulator then clears.
- **Debounce FSM.** It is evaluated only on scan-end cycles. `cnt` is 4 bits.
  - IDLE: result is a key → CAND, cand=code, cnt=1 (if DEBOUNCE_SCANS=1, go directly to PRESSED instead). Result is NONE → stay.
  - CAND:
    - result == cand → cnt+1. When cnt+1 == DEBOUNCE_SCANS → PRESSED and accept.
    - result is a different key → cand=code, cnt=1.
    - result is NONE → IDLE.
  - PRESSED: result is NONE → RELEASE, cnt=1 (if DEBOUNCE_SCANS=1, go directly to IDLE). Any key → stay; a second key never generates an event until release.
  - RELEASE: result is NONE → cnt+1, and at DEBOUNCE_SCANS → IDLE. Any key → PRESSED with no new event.
- **Accept.**
  - `key_code` ← cand.
  - `key_valid` ← 1.
  - If `key_valid` was already 1 and `key_ack` is not high in that cycle, `key_overrun` ← 1.
- **`key_pressed`** = 1 in PRESSED and RELEASE, 0 in IDLE and CAND.
- **Handshake.**
  - `key_valid`=1 and `key_ack`=1 in the same cycle → `key_valid`=0 and `key_overrun`=0 on the next cycle.
  - An accept in the same cycle as an ack wins: `key_valid` stays 1, `key_code` takes the new code, and `key_overrun` stays 0.
  - `key_ack` while `key_valid`=0 is ignored.
- **Code stability.** `key_code` is stable while `key_valid`=1, except on an overrun accept.

## Timing
- **Reset values** (the cycle after `sys_rst` is sampled high):
  - `btn_key_col`=4'b1110.
  - `key_code`=0, `key_valid`=0, `key_pressed`=0, `key_overrun`=0.
  - FSM=IDLE; divider, col_idx, cnt and the scan accumulator are all 0.
- **Reset mid-operation.** Reset from any state behaves identically. No event in progress completes after reset.
- **Scan period.** One full scan takes 4*SCAN_DIV cycles. Each column is driven for exactly SCAN_DIV cycles.
- **Sampling margin.** Sampling at SCAN_DIV-1 leaves at least 2 cycles after a column change for the synchronizer; this is why SCAN_DIV ≥ 4.
- **Press latency.** `key_valid` rises 1 cycle after the scan-end edge that completes DEBOUNCE_SCANS matching scans. A press held stable from time t yields `key_valid` by t + (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- **Ack latency.** `key_valid` falls 1 cycle after the ack cycle.

## Test plan
Bench uses SCAN_DIV=4 and DEBOUNCE_SCANS=2 (scan = 16 cycles). A keypad model drives `btn_key_row` from the current `btn_key_col` and a set of pressed keys.
- **Reset / scan order.** Assert `sys_rst` for 5 cycles, then release → all outputs at reset values. `btn_key_col` then steps 1110→1101→1011→0111→1110, changing every 4 cycles.
- **Single press + ack.** Press row 0/col 0 → `key_code`=0 and `key_valid`=1 within 51 cycles. `key_valid` holds until ack, then falls 1 cycle after ack.
- **Hold / release.** Press row 3/col 3 → `key_code`=15 and `key_pressed`=1. Release → `key_pressed` falls after 2 NONE scans. No second `key_valid` is generated while the key is held.
- **Bounce.** Press for 1 scan only, then release → `key_valid` and `key_pressed` stay 0.
- **Overrun.**
  - Press/release code 6, then press/release code 9, with no ack → `key_code`=9 and `key_overrun`=1. A single ack clears both `key_valid` and `key_overrun`.
  - Repeat with ack coinciding with the accept of code 9 → `key_valid`=1, `key_code`=9, `key_overrun`=0.
- **Multi-key and reset.**
  - Press codes 5 and 10 together → `key_code`=5.
  - Assert reset while in CAND → no `key_valid`, and all outputs return to their reset values.
